// File: rtl/pc_unit_pkg.sv
// Shared types and helpers for the Gumnut program-counter unit.
package pc_unit_pkg;

    typedef enum logic [3:0] {
        OP_INC  = 4'd0,
        OP_BZ   = 4'd1,
        OP_BNZ  = 4'd2,
        OP_BC   = 4'd3,
        OP_BNC  = 4'd4,
        OP_JMP  = 4'd5,
        OP_JSB  = 4'd6,
        OP_RET  = 4'd7,
        OP_RETI = 4'd8,
        OP_INT  = 4'd9
    } pc_op_e;

    // Sign-extend the low disp_w bits of disp to 32 bits.
    function automatic logic [31:0] sext_disp(input logic [31:0] disp, input int unsigned disp_w);
        logic [31:0] w_shl;
        w_shl = disp << (32 - disp_w);
        return 32'($signed(w_shl) >>> (32 - disp_w));
    endfunction

endpackage

// File: rtl/pc_lifo.sv
// Pointer-based LIFO; pushes while full and pops while empty are dropped.
module pc_lifo #(
    parameter int unsigned W     = 12,
    parameter int unsigned DEPTH = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_en,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [W-1:0]                   i_din,
    output logic [W-1:0]                   o_dout_c,
    output logic                           o_full_c,
    output logic                           o_empty_c,
    output logic [$clog2(DEPTH+1)-1:0]     o_level
);

    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [LVL_W-1:0] r_level;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_top_idx;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full_c  = (r_level == LVL_W'(DEPTH));
    assign o_empty_c = (r_level == '0);
    assign w_do_push = i_en && i_push && !o_full_c;
    assign w_do_pop  = i_en && i_pop && !i_push && !o_empty_c;
    assign w_wr_idx  = IDX_W'(r_level);
    assign w_top_idx = IDX_W'(r_level - LVL_W'(1));
    assign o_dout_c  = r_mem[w_top_idx];
    assign o_level   = r_level;

    // Only the pointer is reset; entries above it are never read.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_level <= '0;
        end else if (w_do_push) begin
            r_level <= r_level + LVL_W'(1);
        end else if (w_do_pop) begin
            r_level <= r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_do_push) begin
            r_mem[w_wr_idx] <= i_din;
        end
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Program counter with return-address stack and nested interrupt shadow stack.
module pc_seq_unit
    import pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DISP_W      = 8,
    parameter int unsigned STACK_DEPTH = 8,
    parameter int unsigned INT_DEPTH   = 2,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned INT_VECTOR  = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               ClkEn_e,
    input  logic                               PCEn_c,
    input  logic [3:0]                         PCoper_c,
    input  logic                               ccC_e,
    input  logic                               ccZ_e,
    input  logic [DISP_W-1:0]                  disp_e,
    input  logic [ADDR_W-1:0]                  addr_e,
    input  logic                               err_clr_i,
    output logic [ADDR_W-1:0]                  inst_addr_o,
    output logic                               intc_o,
    output logic                               intz_o,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stk_lvl_o,
    output logic [$clog2(INT_DEPTH+1)-1:0]     int_lvl_o,
    output logic                               stk_ovf_o,
    output logic                               stk_unf_o,
    output logic                               int_ovf_o
);

    localparam int unsigned SH_W = ADDR_W + 2;

    logic [ADDR_W-1:0] r_pc;
    logic              r_intc;
    logic              r_intz;
    logic              r_stk_ovf;
    logic              r_stk_unf;
    logic              r_int_ovf;

    pc_op_e            w_op;
    logic              w_upd;
    logic [ADDR_W-1:0] w_seq;
    logic [ADDR_W-1:0] w_rel;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_rs_push;
    logic              w_rs_pop;
    logic              w_sh_push;
    logic              w_sh_pop;
    logic              w_restore;
    logic              w_set_sovf;
    logic              w_set_sunf;
    logic              w_set_iovf;
    logic [ADDR_W-1:0] w_rs_dout;
    logic              w_rs_full;
    logic              w_rs_empty;
    logic [SH_W-1:0]   w_sh_dout;
    logic              w_sh_full;
    logic              w_sh_empty;

    assign w_upd = ClkEn_e && PCEn_c;
    assign w_op  = pc_op_e'(PCoper_c);
    assign w_seq = r_pc + ADDR_W'(1);
    assign w_rel = w_seq + ADDR_W'(sext_disp(32'(disp_e), DISP_W));

    pc_lifo #(.W(ADDR_W), .DEPTH(STACK_DEPTH)) u_ret_stack (
        .i_clk     (clk_i),
        .i_rst_n   (rst_i),
        .i_en      (w_upd),
        .i_push    (w_rs_push),
        .i_pop     (w_rs_pop),
        .i_din     (w_seq),
        .o_dout_c  (w_rs_dout),
        .o_full_c  (w_rs_full),
        .o_empty_c (w_rs_empty),
        .o_level   (stk_lvl_o)
    );

    pc_lifo #(.W(SH_W), .DEPTH(INT_DEPTH)) u_int_shadow (
        .i_clk     (clk_i),
        .i_rst_n   (rst_i),
        .i_en      (w_upd),
        .i_push    (w_sh_push),
        .i_pop     (w_sh_pop),
        .i_din     ({r_pc, ccC_e, ccZ_e}),
        .o_dout_c  (w_sh_dout),
        .o_full_c  (w_sh_full),
        .o_empty_c (w_sh_empty),
        .o_level   (int_lvl_o)
    );

    // Next-PC selection and stack/error side effects of the current op.
    always_comb begin
        w_next_pc  = w_seq;
        w_rs_push  = 1'b0;
        w_rs_pop   = 1'b0;
        w_sh_push  = 1'b0;
        w_sh_pop   = 1'b0;
        w_restore  = 1'b0;
        w_set_sovf = 1'b0;
        w_set_sunf = 1'b0;
        w_set_iovf = 1'b0;
        case (w_op)
            OP_BZ:   if (ccZ_e)  w_next_pc = w_rel;
            OP_BNZ:  if (!ccZ_e) w_next_pc = w_rel;
            OP_BC:   if (ccC_e)  w_next_pc = w_rel;
            OP_BNC:  if (!ccC_e) w_next_pc = w_rel;
            OP_JMP:  w_next_pc = addr_e;
            OP_JSB: begin
                w_next_pc  = addr_e;
                w_rs_push  = !w_rs_full;
                w_set_sovf = w_rs_full;
            end
            OP_RET: begin
                if (w_rs_empty) begin
                    w_set_sunf = 1'b1;
                end else begin
                    w_next_pc = w_rs_dout;
                    w_rs_pop  = 1'b1;
                end
            end
            OP_RETI: begin
                if (w_sh_empty) begin
                    w_set_sunf = 1'b1;
                end else begin
                    w_next_pc = w_sh_dout[SH_W-1:2];
                    w_sh_pop  = 1'b1;
                    w_restore = 1'b1;
                end
            end
            OP_INT: begin
                if (w_sh_full) begin
                    w_set_iovf = 1'b1;
                end else begin
                    w_next_pc = ADDR_W'(INT_VECTOR);
                    w_sh_push = 1'b1;
                end
            end
            default: w_next_pc = w_seq;
        endcase
    end

    // Error clear needs only the clock enable and beats a same-cycle set.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pc      <= ADDR_W'(RESET_PC);
            r_intc    <= 1'b0;
            r_intz    <= 1'b0;
            r_stk_ovf <= 1'b0;
            r_stk_unf <= 1'b0;
            r_int_ovf <= 1'b0;
        end else if (ClkEn_e) begin
            if (PCEn_c) begin
                r_pc <= w_next_pc;
                if (w_restore) begin
                    r_intc <= w_sh_dout[1];
                    r_intz <= w_sh_dout[0];
                end
            end
            if (err_clr_i) begin
                r_stk_ovf <= 1'b0;
                r_stk_unf <= 1'b0;
                r_int_ovf <= 1'b0;
            end else if (PCEn_c) begin
                r_stk_ovf <= r_stk_ovf | w_set_sovf;
                r_stk_unf <= r_stk_unf | w_set_sunf;
                r_int_ovf <= r_int_ovf | w_set_iovf;
            end
        end
    end

    assign inst_addr_o = r_pc;
    assign intc_o      = r_intc;
    assign intz_o      = r_intz;
    assign stk_ovf_o   = r_stk_ovf;
    assign stk_unf_o   = r_stk_unf;
    assign int_ovf_o   = r_int_ovf;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: vector table, directed corner sequences, random vs. queue model.
module tb_pc_seq_unit;
    import pc_unit_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        ClkEn_e = 1'b0;
    logic        PCEn_c = 1'b0;
    logic [3:0]  PCoper_c = 4'd0;
    logic        ccC_e = 1'b0;
    logic        ccZ_e = 1'b0;
    logic [7:0]  disp_e = 8'd0;
    logic [11:0] addr_e = 12'd0;
    logic        err_clr_i = 1'b0;
    logic [11:0] inst_addr_o;
    logic        intc_o;
    logic        intz_o;
    logic [3:0]  stk_lvl_o;
    logic [1:0]  int_lvl_o;
    logic        stk_ovf_o;
    logic        stk_unf_o;
    logic        int_ovf_o;

    pc_seq_unit #(
        .ADDR_W(12), .DISP_W(8), .STACK_DEPTH(8), .INT_DEPTH(2), .RESET_PC(0), .INT_VECTOR(1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ClkEn_e(ClkEn_e), .PCEn_c(PCEn_c), .PCoper_c(PCoper_c),
        .ccC_e(ccC_e), .ccZ_e(ccZ_e), .disp_e(disp_e), .addr_e(addr_e), .err_clr_i(err_clr_i),
        .inst_addr_o(inst_addr_o), .intc_o(intc_o), .intz_o(intz_o), .stk_lvl_o(stk_lvl_o),
        .int_lvl_o(int_lvl_o), .stk_ovf_o(stk_ovf_o), .stk_unf_o(stk_unf_o), .int_ovf_o(int_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int pc;
        bit c;
        bit z;
    } shadow_t;

    typedef struct {
        logic [11:0] start;
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [7:0]  disp;
        logic [11:0] addr;
        logic [11:0] exp_pc;
    } vec_t;

    int      errors = 0;
    int      checks = 0;
    int      m_pc = 0;
    bit      m_c, m_z, m_sovf, m_sunf, m_iovf;
    int      rs_q[$];
    shadow_t sh_q[$];
    vec_t    vecs[11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: PC as an integer mod 4096, stacks as queues.
    task automatic model_edge(input logic [3:0] op, input logic c, input logic z, input logic [7:0] disp,
                              input logic [11:0] addr, input logic clken, input logic pcen,
                              input logic errclr, input logic rstn);
        int seq, rel, nxt;
        bit so, su, io;
        shadow_t e;
        so = 0; su = 0; io = 0;
        if (!rstn) begin
            m_pc = 0; m_c = 0; m_z = 0; m_sovf = 0; m_sunf = 0; m_iovf = 0;
            rs_q.delete(); sh_q.delete();
            return;
        end
        if (!clken) return;
        if (pcen) begin
            seq = (m_pc + 1) % 4096;
            rel = (m_pc + 1 + int'($signed(disp))) & 'hFFF;
            nxt = seq;
            case (op)
                4'd1: if (z)  nxt = rel;
                4'd2: if (!z) nxt = rel;
                4'd3: if (c)  nxt = rel;
                4'd4: if (!c) nxt = rel;
                4'd5: nxt = int'(addr);
                4'd6: begin
                    nxt = int'(addr);
                    if (rs_q.size() < 8) rs_q.push_back(seq); else so = 1;
                end
                4'd7: if (rs_q.size() > 0) nxt = rs_q.pop_back(); else su = 1;
                4'd8: begin
                    if (sh_q.size() > 0) begin
                        e = sh_q.pop_back();
                        nxt = e.pc; m_c = e.c; m_z = e.z;
                    end else su = 1;
                end
                4'd9: begin
                    if (sh_q.size() < 2) begin
                        e.pc = m_pc; e.c = c; e.z = z;
                        sh_q.push_back(e);
                        nxt = 1;
                    end else io = 1;
                end
                default: nxt = seq;
            endcase
            m_pc = nxt;
        end
        if (errclr) begin
            m_sovf = 0; m_sunf = 0; m_iovf = 0;
        end else begin
            m_sovf |= so; m_sunf |= su; m_iovf |= io;
        end
    endtask

    task automatic compare_all();
        check("pc", int'(inst_addr_o), m_pc);
        check("stk_lvl", int'(stk_lvl_o), rs_q.size());
        check("int_lvl", int'(int_lvl_o), sh_q.size());
        check("intc", int'(intc_o), int'(m_c));
        check("intz", int'(intz_o), int'(m_z));
        check("stk_ovf", int'(stk_ovf_o), int'(m_sovf));
        check("stk_unf", int'(stk_unf_o), int'(m_sunf));
        check("int_ovf", int'(int_ovf_o), int'(m_iovf));
    endtask

    task automatic step(input logic [3:0] op, input logic c, input logic z, input logic [7:0] disp,
                        input logic [11:0] addr, input logic clken, input logic pcen,
                        input logic errclr, input logic rstn);
        PCoper_c = op; ccC_e = c; ccZ_e = z; disp_e = disp; addr_e = addr;
        ClkEn_e = clken; PCEn_c = pcen; err_clr_i = errclr; rst_i = rstn;
        @(posedge clk_i);
        model_edge(op, c, z, disp, addr, clken, pcen, errclr, rstn);
        #1;
        compare_all();
    endtask

    task automatic do_op(input logic [3:0] op, input logic c, input logic z, input logic [7:0] disp,
                         input logic [11:0] addr);
        step(op, c, z, disp, addr, 1'b1, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic do_rst();
        step(4'd0, 1'b0, 1'b0, 8'd0, 12'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [3:0] rop;
        int r;

        vecs[0]  = '{12'hFFE, OP_BZ,  1'b0, 1'b1, 8'h01, 12'h000, 12'h000};
        vecs[1]  = '{12'h010, OP_BNC, 1'b0, 1'b0, 8'hF0, 12'h000, 12'h001};
        vecs[2]  = '{12'hFFE, OP_BZ,  1'b0, 1'b0, 8'h01, 12'h000, 12'hFFF};
        vecs[3]  = '{12'h010, OP_BNC, 1'b1, 1'b0, 8'hF0, 12'h000, 12'h011};
        vecs[4]  = '{12'h100, OP_BNZ, 1'b0, 1'b0, 8'h7F, 12'h000, 12'h180};
        vecs[5]  = '{12'h200, OP_BC,  1'b1, 1'b0, 8'h80, 12'h000, 12'h181};
        vecs[6]  = '{12'h200, OP_BC,  1'b0, 1'b0, 8'h80, 12'h000, 12'h201};
        vecs[7]  = '{12'h100, OP_BNZ, 1'b0, 1'b1, 8'h7F, 12'h000, 12'h101};
        vecs[8]  = '{12'hFFF, OP_INC, 1'b1, 1'b1, 8'h55, 12'h000, 12'h000};
        vecs[9]  = '{12'h123, OP_JMP, 1'b0, 1'b0, 8'h00, 12'h3AA, 12'h3AA};
        vecs[10] = '{12'h040, 4'hF,   1'b0, 1'b0, 8'h10, 12'h777, 12'h041};

        // T1: activity then reset
        do_rst();
        do_op(OP_JSB, 1'b0, 1'b0, 8'd0, 12'h0AB);
        do_op(OP_INT, 1'b1, 1'b1, 8'd0, 12'd0);
        do_op(OP_RET, 1'b0, 1'b0, 8'd0, 12'd0);
        do_op(OP_RET, 1'b0, 1'b0, 8'd0, 12'd0);
        do_rst();
        check("t1_pc", int'(inst_addr_o), 0);
        check("t1_stk_lvl", int'(stk_lvl_o), 0);
        check("t1_flags", int'({stk_ovf_o, stk_unf_o, int_ovf_o, intc_o, intz_o}), 0);

        // T2: branch table
        for (int i = 0; i < 11; i++) begin
            do_op(OP_JMP, 1'b0, 1'b0, 8'd0, vecs[i].start);
            do_op(vecs[i].op, vecs[i].c, vecs[i].z, vecs[i].disp, vecs[i].addr);
            check($sformatf("vec%0d_pc", i), int'(inst_addr_o), int'(vecs[i].exp_pc));
        end

        // T3: call depth overflow and unwind
        do_rst();
        for (int i = 0; i < 9; i++) do_op(OP_JSB, 1'b0, 1'b0, 8'd0, 12'h100);
        check("t3_lvl", int'(stk_lvl_o), 8);
        check("t3_ovf", int'(stk_ovf_o), 1);
        check("t3_pc", int'(inst_addr_o), 'h100);
        for (int i = 0; i < 7; i++) do_op(OP_RET, 1'b0, 1'b0, 8'd0, 12'd0);
        check("t3_ret7_pc", int'(inst_addr_o), 'h101);
        do_op(OP_RET, 1'b0, 1'b0, 8'd0, 12'd0);
        check("t3_ret8_pc", int'(inst_addr_o), 'h001);
        check("t3_unf_before", int'(stk_unf_o), 0);
        do_op(OP_RET, 1'b0, 1'b0, 8'd0, 12'd0);
        check("t3_unf", int'(stk_unf_o), 1);
        check("t3_ret9_pc", int'(inst_addr_o), 'h002);

        // T4: nested interrupts
        do_op(OP_JMP, 1'b0, 1'b0, 8'd0, 12'h050);
        do_op(OP_INT, 1'b1, 1'b0, 8'd0, 12'd0);
        check("t4_int1_pc", int'(inst_addr_o), 1);
        check("t4_int1_lvl", int'(int_lvl_o), 1);
        do_op(OP_INT, 1'b0, 1'b1, 8'd0, 12'd0);
        check("t4_int2_lvl", int'(int_lvl_o), 2);
        do_op(OP_INT, 1'b1, 1'b1, 8'd0, 12'd0);
        check("t4_iovf", int'(int_ovf_o), 1);
        check("t4_int3_pc", int'(inst_addr_o), 2);
        do_op(OP_RETI, 1'b0, 1'b0, 8'd0, 12'd0);
        check("t4_reti1_pc", int'(inst_addr_o), 1);
        check("t4_reti1_cz", int'({intc_o, intz_o}), 1);
        do_op(OP_RETI, 1'b0, 1'b0, 8'd0, 12'd0);
        check("t4_reti2_pc", int'(inst_addr_o), 'h050);
        check("t4_reti2_cz", int'({intc_o, intz_o}), 2);

        // T5: enables and error clear
        step(OP_JMP, 1'b0, 1'b0, 8'd0, 12'h3AA, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t5_clken_pc", int'(inst_addr_o), 'h050);
        check("t5_clken_flags", int'({stk_ovf_o, stk_unf_o, int_ovf_o}), 7);
        step(OP_JMP, 1'b0, 1'b0, 8'd0, 12'h3AA, 1'b1, 1'b0, 1'b0, 1'b1);
        check("t5_pcen_pc", int'(inst_addr_o), 'h050);
        step(OP_RET, 1'b0, 1'b0, 8'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("t5_clr_flags", int'({stk_ovf_o, stk_unf_o, int_ovf_o}), 0);
        check("t5_clr_pc", int'(inst_addr_o), 'h051);

        // T6: reset mid-sequence
        do_rst();
        for (int i = 0; i < 3; i++) do_op(OP_JSB, 1'b0, 1'b0, 8'd0, 12'h200);
        do_op(OP_INT, 1'b1, 1'b1, 8'd0, 12'd0);
        check("t6_pre_lvls", int'({stk_lvl_o, int_lvl_o}), 'hD);
        do_rst();
        check("t6_lvls", int'({stk_lvl_o, int_lvl_o}), 0);
        do_op(OP_RET, 1'b0, 1'b0, 8'd0, 12'd0);
        check("t6_unf", int'(stk_unf_o), 1);
        check("t6_pc", int'(inst_addr_o), 1);

        // Random traffic against the queue model
        do_rst();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 25)      rop = OP_JSB;
            else if (r < 45) rop = OP_RET;
            else if (r < 55) rop = OP_INT;
            else if (r < 65) rop = OP_RETI;
            else             rop = 4'($urandom_range(0, 15));
            step(rop, 1'($urandom), 1'($urandom), 8'($urandom), 12'($urandom),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 6) != 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 49) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
